error_campaign_ctrl: RTL and testbench
======================================

ERROR_CAMPAIGN_CTRL -- requirements
Module: error_campaign_ctrl

Interface
REQ-001 SHALL have parameter N, default 11, data bits per word.
REQ-002 SHALL have parameter R, default 4, parity bits; 2^R >= N+R+1 is the integrator's responsibility.
REQ-003 SHALL have parameter NUM_WORDS, default 64, words per campaign, range 1..65535.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle campaign request.
REQ-007 SHALL have port flips, input, 2, errors injected per word (0, 1 or 2); value 3 is treated as 2.
REQ-008 SHALL have port stream, output, [1:N], data word to the encoder.
REQ-009 SHALL have port flipMask, output, [1:N+R], XOR mask applied to the encoded word.
REQ-010 SHALL have port outStream, input, [1:N], decoder result (combinational path from stream and flipMask).
REQ-011 SHALL have port busy, output, 1, campaign in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at campaign end.
REQ-013 SHALL have port wordCnt, output, 16, words checked.
REQ-014 SHALL have port errCnt, output, 16, words with outStream != stream.

Function
REQ-015 SHALL implement states IDLE, DRIVE, CHECK, FINISH.
REQ-016 IDLE: start=1 SHALL latch flips, clear wordCnt/errCnt, reset the position counter to 1, and go to DRIVE.
REQ-017 DRIVE: SHALL register a new stream word from an internal 11-tap-style Fibonacci LFSR (width N, taps in package, nonzero seed 'd2) and a new flipMask, then go to CHECK.
REQ-018 Mask rule: with position p (1..N+R): flips=0 gives all zeros; flips=1 sets bit p; flips=2 sets bits p and (p mod (N+R))+1.
REQ-019 CHECK: SHALL compare outStream with the registered stream, increment wordCnt, increment errCnt on mismatch, and advance p with wrap N+R -> 1.
REQ-020 CHECK: SHALL go to FINISH when wordCnt reaches NUM_WORDS after increment; otherwise it SHALL return to DRIVE.
REQ-021 FINISH: SHALL assert done for exactly one cycle, then go to IDLE.
REQ-022 Latency SHALL be 2 cycles per word; done SHALL occur 2*NUM_WORDS+1 cycles after the start cycle.
REQ-023 busy SHALL be 1 in DRIVE, CHECK and FINISH, and 0 in IDLE.
REQ-024 start while busy SHALL be ignored.
REQ-025 Counters SHALL saturate at 16'hFFFF.
REQ-026 wordCnt and errCnt SHALL hold their values after done until the next accepted start.
REQ-027 flipMask SHALL be zero in IDLE; stream SHALL hold its last value in IDLE.

Reset
REQ-028 reset SHALL force IDLE asynchronously and set stream=N'd2, flipMask=0, busy=0, done=0, wordCnt=0, errCnt=0, p=1, and LFSR=seed.
REQ-029 reset mid-campaign SHALL abort with no done pulse; the next start SHALL begin a fresh campaign.

Configuration
REQ-030 With ERR_CAMPAIGN_STOP_ON_ERROR_EN defined, the first mismatch in CHECK SHALL go directly to FINISH, pulse done, and leave errCnt=1 with wordCnt including the failing word; an added output failWord[1:N] SHALL capture the failing outStream (reset 0).
REQ-031 With ERR_CAMPAIGN_STOP_ON_ERROR_EN undefined, the campaign SHALL always run NUM_WORDS words and the failWord port SHALL be absent.

Structure
REQ-032 A shared package SHALL hold the state enum, the LFSR tap constant, the seed constant, and the counter width constant (16).
REQ-033 Mask generation SHALL be one sub-module, flip_mask_gen (inputs p and flips; output mask; combinational), instantiated once.
REQ-034 The decoder SHALL be external; the block SHALL contain no Hamming logic.

Verification
REQ-035 Scenario: reset, flips=0, start, NUM_WORDS=64 -> done at cycle 129 after start, wordCnt=64, errCnt=0.
REQ-036 Scenario: flips=1 with N=11, R=4 and a correct decoder -> errCnt=0; flipMask visits bits 1..15 and then wraps to bit 1 on word 16.
REQ-037 Scenario: flips=2 -> errCnt>0 (the encoder/decoder are SEC only); mask for p=15 has bits 15 and 1 set.
REQ-038 Scenario: reset asserted during the CHECK of word 10 -> immediate IDLE, counters 0, no done; a restart completes normally.
REQ-039 Scenario: start pulsed while busy -> ignored; counters are unaffected.
REQ-040 Scenario (ERR_CAMPAIGN_STOP_ON_ERROR_EN): flips=2 -> done after the first mismatch, errCnt=1, and failWord equals outStream from that cycle.

Source files
------------

// File: rtl/error_campaign_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// error_campaign_ctrl_pkg
// Shared definitions for the error-injection campaign controller:
//   - campaign FSM state encoding (constants plus enum type)
//   - flips encodings understood by the mask generator
//   - LFSR feedback tap constant and seed (bit i set = tap on lfsr bit i)
//   - counter width and a saturating increment helper
// -----------------------------------------------------------------------------
package error_campaign_ctrl_pkg;

  // Width of the word and error counters.
  localparam int CNT_W = 16;

  // FSM state encodings, kept as plain constants for legacy users.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_DRIVE  = ST_DRIVE,
    S_CHECK  = ST_CHECK,
    S_FINISH = ST_FINISH
  } state_e;

  // Injected-error encodings (3 is folded to FLIPS_TWO before use).
  localparam logic [1:0] FLIPS_NONE = 2'd0;
  localparam logic [1:0] FLIPS_ONE  = 2'd1;
  localparam logic [1:0] FLIPS_TWO  = 2'd2;

  // Fibonacci LFSR taps, numeric bit i = tap on register bit i (LSB = 0).
  // x^11 + x^9 + 1 for the default 11-bit word: taps on bits 10 and 8.
  localparam logic [63:0] LFSR_TAPS = 64'h0000_0000_0000_0500;
  localparam logic [63:0] LFSR_SEED = 64'd2;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/error_campaign_ctrl_flip_mask_gen.sv
// -----------------------------------------------------------------------------
// flip_mask_gen
// Combinational error-mask generator for the campaign controller.
//   p     : current bit position, valid range 1..W
//   flips : 0 = no error, 1 = bit p, 2 = bits p and (p mod W)+1
//   mask  : [1:W] XOR mask for the encoded word (bit index = position)
// -----------------------------------------------------------------------------
module flip_mask_gen
  import error_campaign_ctrl_pkg::*;
#(
  parameter int W  = 15,
  parameter int PW = $clog2(W + 1)
) (
  input  logic [PW-1:0] p,
  input  logic [1:0]    flips,
  output logic [1:W]    mask
);

  logic [PW-1:0] p2_s;

  // Build the mask: first error at p, second error at the next position with wrap.
  always_comb begin
    mask = '0;
    if (p == PW'(W)) begin
      p2_s = PW'(1);
    end else begin
      p2_s = p + PW'(1);
    end
    for (int i = 1; i <= W; i++) begin
      if ((flips != FLIPS_NONE) && (p == PW'(i))) begin
        mask[i] = 1'b1;
      end else if ((flips == FLIPS_TWO) && (p2_s == PW'(i))) begin
        mask[i] = 1'b1;
      end else begin
        mask[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/error_campaign_ctrl.sv
// -----------------------------------------------------------------------------
// error_campaign_ctrl
// Runs an error-injection campaign against an external encoder/decoder pair.
// Each word takes two cycles: DRIVE registers a new LFSR data word and an
// error mask, CHECK compares the decoder result with the word sent.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      one-cycle campaign request (ignored while busy)
//   flips      errors per word: 0, 1, 2 (3 behaves as 2)
//   stream     [1:N] data word to the encoder
//   flipMask   [1:N+R] XOR mask for the encoded word
//   outStream  [1:N] decoder result, combinational from stream/flipMask
//   busy       high in DRIVE, CHECK and FINISH
//   done       one-cycle pulse in FINISH
//   wordCnt    words checked (saturating)
//   errCnt     words whose decoder result differed from stream (saturating)
//   failWord   [1:N] outStream of the failing word (only with macro below)
//
// Build option: ERR_CAMPAIGN_STOP_ON_ERROR_EN -- stop the campaign at the
// first mismatching word and expose failWord.
// -----------------------------------------------------------------------------
module error_campaign_ctrl
  import error_campaign_ctrl_pkg::*;
#(
  parameter int N         = 11,
  parameter int R         = 4,
  parameter int NUM_WORDS = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       flips,
  output logic [1:N]       stream,
  output logic [1:N+R]     flipMask,
  input  logic [1:N]       outStream,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] wordCnt,
  output logic [CNT_W-1:0] errCnt
`ifdef ERR_CAMPAIGN_STOP_ON_ERROR_EN
  ,
  output logic [1:N]       failWord
`endif
);

  localparam int         W    = N + R;
  localparam int         PW   = $clog2(W + 1);
  localparam logic [1:N] TAPS = LFSR_TAPS[N-1:0];
  localparam logic [1:N] SEED = LFSR_SEED[N-1:0];

  state_e          state_r;
  logic [1:N]      lfsr_r;
  logic [PW-1:0]   p_r;
  logic [1:0]      flips_r;

  logic            fb_s;
  logic [1:N]      lfsr_next_s;
  logic [PW-1:0]   p_next_s;
  logic [1:W]      mask_s;
  logic            mismatch_s;
  logic [CNT_W-1:0] wcnt_inc_s;
  logic [CNT_W-1:0] ecnt_inc_s;
  logic            finish_s;

  flip_mask_gen #(
    .W  (W),
    .PW (PW)
  ) u_flip_mask_gen (
    .p     (p_r),
    .flips (flips_r),
    .mask  (mask_s)
  );

  // Next-value logic: LFSR step, position wrap, compare and end-of-campaign test.
  always_comb begin
    // The vector is [1:N], so [2:N] is the low N-1 bits shifting up.
    fb_s        = ^(lfsr_r & TAPS);
    lfsr_next_s = {lfsr_r[2:N], fb_s};
    if (p_r == PW'(W)) begin
      p_next_s = PW'(1);
    end else begin
      p_next_s = p_r + PW'(1);
    end
    mismatch_s = (outStream != stream);
    wcnt_inc_s = sat_inc(wordCnt);
    ecnt_inc_s = sat_inc(errCnt);
`ifdef ERR_CAMPAIGN_STOP_ON_ERROR_EN
    finish_s = (wcnt_inc_s == CNT_W'(NUM_WORDS)) || mismatch_s;
`else
    finish_s = (wcnt_inc_s == CNT_W'(NUM_WORDS));
`endif
  end

  // Campaign FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= S_IDLE;
      lfsr_r   <= SEED;
      p_r      <= PW'(1);
      flips_r  <= FLIPS_NONE;
      stream   <= SEED;
      flipMask <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wordCnt  <= '0;
      errCnt   <= '0;
`ifdef ERR_CAMPAIGN_STOP_ON_ERROR_EN
      failWord <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            flips_r <= (flips == 2'd3) ? FLIPS_TWO : flips;
            wordCnt <= '0;
            errCnt  <= '0;
            p_r     <= PW'(1);
            busy    <= 1'b1;
            state_r <= S_DRIVE;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_DRIVE: begin
          lfsr_r   <= lfsr_next_s;
          stream   <= lfsr_next_s;
          flipMask <= mask_s;
          state_r  <= S_CHECK;
        end
        S_CHECK: begin
          wordCnt <= wcnt_inc_s;
          if (mismatch_s) begin
            errCnt <= ecnt_inc_s;
`ifdef ERR_CAMPAIGN_STOP_ON_ERROR_EN
            failWord <= outStream;
`endif
          end else begin
            errCnt <= errCnt;
          end
          p_r <= p_next_s;
          if (finish_s) begin
            done    <= 1'b1;
            state_r <= S_FINISH;
          end else begin
            state_r <= S_DRIVE;
          end
        end
        S_FINISH: begin
          // Mask goes quiet on the way back to IDLE; stream keeps its value.
          flipMask <= '0;
          busy     <= 1'b0;
          state_r  <= S_IDLE;
        end
        default: begin
          flipMask <= '0;
          busy     <= 1'b0;
          state_r  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_error_campaign_ctrl.sv
// -----------------------------------------------------------------------------
// tb_error_campaign_ctrl
// Self-checking bench for error_campaign_ctrl with N=11, R=4, NUM_WORDS=64.
// A behavioural Hamming(15,11) SEC encoder/decoder closes the loop from
// stream/flipMask to outStream. Expected results come from the campaign rules:
// word w uses position ((w-1) mod 15)+1, and a double error corrupts the data
// whenever any of the three toggled positions (p, q and the miscorrected
// p^q) is a data position.
// -----------------------------------------------------------------------------
module tb_error_campaign_ctrl;

  localparam int N  = 11;
  localparam int R  = 4;
  localparam int W  = N + R;
  localparam int NW = 64;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    flips;
  logic [1:N]    stream;
  logic [1:W]    flipMask;
  logic [1:N]    outStream;
  logic          busy;
  logic          done;
  logic [15:0]   wordCnt;
  logic [15:0]   errCnt;
`ifdef ERR_CAMPAIGN_STOP_ON_ERROR_EN
  logic [1:N]    failWord;
`endif

  int checks = 0;
  int errors = 0;

  // Runner results
  int         model_lfsr;
  int         done_cyc;
  int         seq_bad;
  string      first_bad;
  int         exp_err;
  logic [1:W] obs_mask [1:NW];

  error_campaign_ctrl #(
    .N         (N),
    .R         (R),
    .NUM_WORDS (NW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .flips     (flips),
    .stream    (stream),
    .flipMask  (flipMask),
    .outStream (outStream),
    .busy      (busy),
    .done      (done),
    .wordCnt   (wordCnt),
    .errCnt    (errCnt)
`ifdef ERR_CAMPAIGN_STOP_ON_ERROR_EN
    ,
    .failWord  (failWord)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_pow2(input int x);
    return (x & (x - 1)) == 0;
  endfunction

  // Hamming(15,11) encode, inject mask, single-error correct, extract data.
  function automatic logic [1:N] decode(input logic [1:N] d, input logic [1:W] m);
    logic [1:W] cw;
    logic [1:N] o;
    logic       par;
    int         di;
    int         syn;
    cw = '0;
    o  = '0;
    di = 1;
    for (int pos = 1; pos <= W; pos++) begin
      if (!is_pow2(pos)) begin
        cw[pos] = d[di];
        di++;
      end
    end
    for (int j = 0; j < R; j++) begin
      par = 1'b0;
      for (int pos = 1; pos <= W; pos++) begin
        if (((pos >> j) & 1) == 1 && !is_pow2(pos)) par = par ^ cw[pos];
      end
      cw[1 << j] = par;
    end
    cw  = cw ^ m;
    syn = 0;
    for (int pos = 1; pos <= W; pos++) begin
      if (cw[pos]) syn = syn ^ pos;
    end
    if (syn != 0) cw[syn] = ~cw[syn];
    di = 1;
    for (int pos = 1; pos <= W; pos++) begin
      if (!is_pow2(pos)) begin
        o[di] = cw[pos];
        di++;
      end
    end
    return o;
  endfunction

  assign outStream = decode(stream, flipMask);

  function automatic int lfsr_step(input int v);
    int fb;
    fb = ((v >> 10) ^ (v >> 8)) & 1;
    return ((v << 1) | fb) & 32'h7FF;
  endfunction

  // 1 if a word at position p with ef effective flips should miscompare.
  function automatic int word_fails(input int ef, input int p);
    int q;
    if (ef < 2) return 0;
    q = (p % W) + 1;
    return (!is_pow2(p) || !is_pow2(q) || !is_pow2(p ^ q)) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note_bad(input string s);
    seq_bad++;
    if (seq_bad == 1) first_bad = s;
  endtask

  // Runs one campaign from IDLE, recording discrepancies against the model.
  // Leaves the bench one cycle after the done pulse (back in IDLE).
  task automatic run_campaign(input logic [1:0] f, input int stray_pct);
    int ef;
    int p;
    int w;
    logic [1:W] em;
    ef        = (f == 2'd3) ? 2 : int'(f);
    done_cyc  = -1;
    seq_bad   = 0;
    first_bad = "none";
    exp_err   = 0;
    start = 1'b1;
    flips = f;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 2 * NW + 8 && done_cyc < 0; k++) begin
      if (k % 2 == 0 && k <= 2 * NW) begin
        w = k / 2;
        p = ((w - 1) % W) + 1;
        model_lfsr = lfsr_step(model_lfsr);
        em = '0;
        if (ef >= 1) em[p] = 1'b1;
        if (ef == 2) em[(p % W) + 1] = 1'b1;
        obs_mask[w] = flipMask;
        if (stream !== 11'(model_lfsr))
          note_bad($sformatf("word %0d stream %h want %h", w, stream, 11'(model_lfsr)));
        if (flipMask !== em)
          note_bad($sformatf("word %0d mask %b want %b", w, flipMask, em));
        exp_err += word_fails(ef, p);
      end
      if (k % 2 == 1 && k >= 3 && k <= 2 * NW + 1) begin
        if (wordCnt !== 16'((k - 1) / 2))
          note_bad($sformatf("cycle %0d wordCnt %0d want %0d", k, wordCnt, (k - 1) / 2));
        if (errCnt !== 16'(exp_err))
          note_bad($sformatf("cycle %0d errCnt %0d want %0d", k, errCnt, exp_err));
      end
      if (busy !== 1'b1)
        note_bad($sformatf("cycle %0d busy %b want 1", k, busy));
      if (done === 1'b1) done_cyc = k;
      if (k < 2 * NW && $urandom_range(0, 99) < stray_pct) begin
        start = 1'b1;
        flips = 2'($urandom_range(0, 3));
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    flips = 2'd0;
    repeat (2) tick();
    checks += 6;
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    if (wordCnt !== 16'd0)   begin errors++; $display("FAIL reset_wordcnt: got %0d want 0", wordCnt); end
    if (errCnt !== 16'd0)    begin errors++; $display("FAIL reset_errcnt: got %0d want 0", errCnt); end
    if (flipMask !== 15'd0)  begin errors++; $display("FAIL reset_mask: got %b want 0", flipMask); end
    if (stream !== 11'd2)    begin errors++; $display("FAIL reset_stream: got %h want 002", stream); end
    reset = 1'b0;
    model_lfsr = 2;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_flips0();
    run_campaign(2'd0, 0);
    checks += 6;
    if (done_cyc != 2 * NW + 1) begin errors++; $display("FAIL f0_done_cycle: got %0d want %0d", done_cyc, 2 * NW + 1); end
    if (seq_bad != 0)        begin errors++; $display("FAIL f0_sequence: %0d bad, first: %s", seq_bad, first_bad); end
    if (wordCnt !== 16'(NW)) begin errors++; $display("FAIL f0_wordcnt: got %0d want %0d", wordCnt, NW); end
    if (errCnt !== 16'd0)    begin errors++; $display("FAIL f0_errcnt: got %0d want 0", errCnt); end
    if (busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL f0_after: busy %b done %b want 0 0", busy, done); end
    if (flipMask !== 15'd0)  begin errors++; $display("FAIL f0_idle_mask: got %b want 0", flipMask); end
    repeat (5) tick();
    checks += 2;
    if (wordCnt !== 16'(NW) || errCnt !== 16'd0)
      begin errors++; $display("FAIL f0_hold_counts: got %0d/%0d want %0d/0", wordCnt, errCnt, NW); end
    if (stream !== 11'(model_lfsr))
      begin errors++; $display("FAIL f0_hold_stream: got %h want %h", stream, 11'(model_lfsr)); end
  endtask

  task automatic test_flips1();
    logic [1:W] e15;
    logic [1:W] e16;
    run_campaign(2'd1, 0);
    e15 = '0; e15[15] = 1'b1;
    e16 = '0; e16[1]  = 1'b1;
    checks += 5;
    if (done_cyc != 2 * NW + 1) begin errors++; $display("FAIL f1_done_cycle: got %0d want %0d", done_cyc, 2 * NW + 1); end
    if (seq_bad != 0)        begin errors++; $display("FAIL f1_sequence: %0d bad, first: %s", seq_bad, first_bad); end
    if (errCnt !== 16'd0)    begin errors++; $display("FAIL f1_errcnt: got %0d want 0", errCnt); end
    if (obs_mask[15] !== e15) begin errors++; $display("FAIL f1_mask_w15: got %b want %b", obs_mask[15], e15); end
    if (obs_mask[16] !== e16) begin errors++; $display("FAIL f1_mask_wrap: got %b want %b", obs_mask[16], e16); end
  endtask

`ifndef ERR_CAMPAIGN_STOP_ON_ERROR_EN
  task automatic test_flips2();
    logic [1:W] e15;
    run_campaign(2'd2, 0);
    e15 = '0; e15[15] = 1'b1; e15[1] = 1'b1;
    checks += 5;
    if (done_cyc != 2 * NW + 1) begin errors++; $display("FAIL f2_done_cycle: got %0d want %0d", done_cyc, 2 * NW + 1); end
    if (seq_bad != 0)        begin errors++; $display("FAIL f2_sequence: %0d bad, first: %s", seq_bad, first_bad); end
    if (errCnt !== 16'(exp_err)) begin errors++; $display("FAIL f2_errcnt: got %0d want %0d", errCnt, exp_err); end
    if (errCnt == 16'd0)     begin errors++; $display("FAIL f2_errcnt_nonzero: got 0 want >0"); end
    if (obs_mask[15] !== e15) begin errors++; $display("FAIL f2_mask_w15: got %b want %b", obs_mask[15], e15); end
  endtask
`endif

  task automatic test_busy_start();
    run_campaign(2'd0, 40);
    checks += 4;
    if (done_cyc != 2 * NW + 1) begin errors++; $display("FAIL busy_done_cycle: got %0d want %0d", done_cyc, 2 * NW + 1); end
    if (seq_bad != 0)        begin errors++; $display("FAIL busy_sequence: %0d bad, first: %s", seq_bad, first_bad); end
    if (wordCnt !== 16'(NW)) begin errors++; $display("FAIL busy_wordcnt: got %0d want %0d", wordCnt, NW); end
    if (errCnt !== 16'd0)    begin errors++; $display("FAIL busy_errcnt: got %0d want 0", errCnt); end
  endtask

  task automatic test_reset_abort();
    int dones;
    start = 1'b1;
    flips = 2'd1;
    tick();
    start = 1'b0;
    // 19 more edges: now in CHECK of word 10.
    repeat (19) tick();
    #1 reset = 1'b1;
    #1;
    checks += 5;
    if (busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL abort_flags: busy %b done %b want 0 0", busy, done); end
    if (wordCnt !== 16'd0)  begin errors++; $display("FAIL abort_wordcnt: got %0d want 0", wordCnt); end
    if (errCnt !== 16'd0)   begin errors++; $display("FAIL abort_errcnt: got %0d want 0", errCnt); end
    if (flipMask !== 15'd0) begin errors++; $display("FAIL abort_mask: got %b want 0", flipMask); end
    if (stream !== 11'd2)   begin errors++; $display("FAIL abort_stream: got %h want 002", stream); end
    reset = 1'b0;
    model_lfsr = 2;
    dones = 0;
    for (int k = 0; k < 2 * NW + 5; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", dones); end
    run_campaign(2'd1, 0);
    checks += 3;
    if (done_cyc != 2 * NW + 1) begin errors++; $display("FAIL restart_done_cycle: got %0d want %0d", done_cyc, 2 * NW + 1); end
    if (seq_bad != 0)        begin errors++; $display("FAIL restart_sequence: %0d bad, first: %s", seq_bad, first_bad); end
    if (wordCnt !== 16'(NW) || errCnt !== 16'd0)
      begin errors++; $display("FAIL restart_counts: got %0d/%0d want %0d/0", wordCnt, errCnt, NW); end
  endtask

  task automatic test_random();
    logic [1:0] f;
    for (int c = 0; c < 4; c++) begin
`ifdef ERR_CAMPAIGN_STOP_ON_ERROR_EN
      f = 2'($urandom_range(0, 1));
`else
      f = 2'($urandom_range(0, 3));
`endif
      repeat ($urandom_range(0, 6)) tick();
      run_campaign(f, int'($urandom_range(0, 30)));
      checks += 4;
      if (done_cyc != 2 * NW + 1) begin errors++; $display("FAIL rnd%0d_done_cycle: got %0d want %0d", c, done_cyc, 2 * NW + 1); end
      if (seq_bad != 0)        begin errors++; $display("FAIL rnd%0d_sequence: %0d bad, first: %s", c, seq_bad, first_bad); end
      if (wordCnt !== 16'(NW)) begin errors++; $display("FAIL rnd%0d_wordcnt: got %0d want %0d", c, wordCnt, NW); end
      if (errCnt !== 16'(exp_err)) begin errors++; $display("FAIL rnd%0d_errcnt: got %0d want %0d", c, errCnt, exp_err); end
    end
  endtask

`ifdef ERR_CAMPAIGN_STOP_ON_ERROR_EN
  task automatic test_stop_on_error();
    logic [1:N] seen;
    seen = '0;
    done_cyc = -1;
    start = 1'b1;
    flips = 2'd2;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 10 && done_cyc < 0; k++) begin
      if (k == 2) seen = outStream;
      if (done === 1'b1) done_cyc = k;
      tick();
    end
    model_lfsr = lfsr_step(model_lfsr);
    checks += 4;
    if (done_cyc != 3)     begin errors++; $display("FAIL stop_done_cycle: got %0d want 3", done_cyc); end
    if (errCnt !== 16'd1)  begin errors++; $display("FAIL stop_errcnt: got %0d want 1", errCnt); end
    if (wordCnt !== 16'd1) begin errors++; $display("FAIL stop_wordcnt: got %0d want 1", wordCnt); end
    if (failWord !== seen) begin errors++; $display("FAIL stop_failword: got %h want %h", failWord, seen); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    flips = 2'd0;
    model_lfsr = 2;
    test_reset();
    test_flips0();
    test_flips1();
`ifndef ERR_CAMPAIGN_STOP_ON_ERROR_EN
    test_flips2();
`else
    test_stop_on_error();
`endif
    test_busy_start();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
